// File: rtl/mem_port_arbiter.sv
// Byte-serial RAM/IO controller: NUM_RD_CH read channels plus one write channel on an 8-bit bus.
// Define MEMARB_RR_EN for round-robin read arbitration; otherwise the lowest channel index wins.
module mem_port_arbiter #(
   parameter int NUM_RD_CH = 2,
   parameter int ADDR_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic [7:0]                    mem_din,
   output logic [7:0]                    mem_dout,
   output logic [ADDR_W-1:0]             mem_a,
   output logic                          mem_wr,
   input  logic                          io_buffer_full,
   input  logic                          flush,
   input  logic [NUM_RD_CH-1:0]          rd_req,
   input  logic [NUM_RD_CH*ADDR_W-1:0]   rd_addr,
   input  logic [NUM_RD_CH*2-1:0]        rd_size,
   output logic [NUM_RD_CH-1:0]          rd_done,
   output logic [31:0]                   rd_data,
   input  logic                          wr_req,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [1:0]                    wr_size,
   input  logic [31:0]                   wr_data,
   output logic                          wr_done,
   output logic                          busy
);
   localparam int CH_W = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       asm_q, asm_nxt;
   logic [1:0]        last_idx;
   logic [2:0]        iss_idx;   // byte index currently on mem_a
   logic [1:0]        cap_idx;   // next byte index to capture
   logic              valid;     // mem_din carries byte cap_idx this cycle
   logic [CH_W-1:0]   ch, gnt_ch;
   logic              gnt_valid;
   logic              mem_wr_q, stall, issuing, more_to_issue;
   logic              start_wr, start_rd, rd_finish, wr_finish;

   function automatic logic [1:0] size_to_last(input logic [1:0] size);
      case (size)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

`ifdef MEMARB_RR_EN
   logic [CH_W-1:0] rr_ptr;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_ch    = '0;
      // Descending scan so the channel closest to the pointer is written last and wins.
      for (int k = NUM_RD_CH - 1; k >= 0; k--) begin
         if (rd_req[CH_W'((int'(rr_ptr) + k) % NUM_RD_CH)]) begin
            gnt_valid = 1'b1;
            gnt_ch    = CH_W'((int'(rr_ptr) + k) % NUM_RD_CH);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (rdy && start_rd)
         rr_ptr <= (int'(gnt_ch) == NUM_RD_CH - 1) ? '0 : gnt_ch + 1'b1;
   end
`else
   always_comb begin
      gnt_valid = 1'b0;
      gnt_ch    = '0;
      for (int k = NUM_RD_CH - 1; k >= 0; k--) begin
         if (rd_req[k]) begin
            gnt_valid = 1'b1;
            gnt_ch    = CH_W'(k);
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt     = state;
      start_wr      = 1'b0;
      start_rd      = 1'b0;
      rd_finish     = 1'b0;
      wr_finish     = 1'b0;
      stall         = (base[17:16] == 2'b11) && io_buffer_full;
      issuing       = (iss_idx <= {1'b0, last_idx});
      more_to_issue = (iss_idx < {1'b0, last_idx});
      if (rdy) begin
         unique case (state)
            IDLE:
               if (wr_req) begin
                  start_wr  = 1'b1;
                  state_nxt = WRITE;
               end else if (gnt_valid && !flush) begin
                  start_rd  = 1'b1;
                  state_nxt = READ;
               end
            READ:
               if (flush) begin
                  state_nxt = IDLE;
               end else if (valid && cap_idx == last_idx) begin
                  rd_finish = 1'b1;
                  state_nxt = IDLE;
               end
            WRITE:
               if (!stall && iss_idx == {1'b0, last_idx}) begin
                  wr_finish = 1'b1;
                  state_nxt = IDLE;
               end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state != IDLE);
      mem_wr = mem_wr_q && rdy && !stall;
      asm_nxt = asm_q;
      asm_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base     <= '0;
         wdata    <= '0;
         asm_q    <= '0;
         last_idx <= '0;
         iss_idx  <= '0;
         cap_idx  <= '0;
         valid    <= 1'b0;
         ch       <= '0;
         mem_wr_q <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         rd_done  <= '0;
         rd_data  <= '0;
         wr_done  <= 1'b0;
      end else begin
         rd_done <= '0;
         wr_done <= 1'b0;
         if (!rdy) begin
            // The byte in flight is dropped; rewind so the oldest uncaptured byte is re-issued.
            if (state == READ) begin
               valid   <= 1'b0;
               iss_idx <= {1'b0, cap_idx};
               mem_a   <= base + ADDR_W'(cap_idx);
            end
         end else begin
            unique case (state)
               IDLE:
                  if (start_wr) begin
                     base     <= wr_addr;
                     wdata    <= wr_data;
                     last_idx <= size_to_last(wr_size);
                     iss_idx  <= '0;
                     mem_a    <= wr_addr;
                     mem_dout <= wr_data[7:0];
                     mem_wr_q <= 1'b1;
                  end else if (start_rd) begin
                     base     <= rd_addr[int'(gnt_ch)*ADDR_W +: ADDR_W];
                     last_idx <= size_to_last(rd_size[int'(gnt_ch)*2 +: 2]);
                     ch       <= gnt_ch;
                     iss_idx  <= '0;
                     cap_idx  <= '0;
                     valid    <= 1'b0;
                     asm_q    <= '0;
                     mem_a    <= rd_addr[int'(gnt_ch)*ADDR_W +: ADDR_W];
                  end
               READ:
                  if (!flush) begin
                     if (valid) begin
                        asm_q   <= asm_nxt;
                        cap_idx <= cap_idx + 2'd1;
                        if (rd_finish) begin
                           rd_done[ch] <= 1'b1;
                           rd_data     <= asm_nxt;
                        end
                     end
                     valid <= issuing;
                     if (issuing) iss_idx <= iss_idx + 3'd1;
                     if (more_to_issue) mem_a <= base + ADDR_W'(iss_idx + 3'd1);
                  end
               WRITE:
                  if (!stall) begin
                     if (wr_finish) begin
                        mem_wr_q <= 1'b0;
                        wr_done  <= 1'b1;
                     end else begin
                        iss_idx  <= iss_idx + 3'd1;
                        mem_a    <= base + ADDR_W'(iss_idx + 3'd1);
                        mem_dout <= wdata[{iss_idx[1:0] + 2'd1, 3'b000} +: 8];
                     end
                  end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, byte order, arbitration order, IO stall, flush, rdy freeze, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
   localparam int N  = 2;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rdy = 1'b1;
   logic [7:0]      mem_din = '0;
   logic [7:0]      mem_dout;
   logic [AW-1:0]   mem_a;
   logic            mem_wr;
   logic            io_buffer_full = 1'b0;
   logic            flush = 1'b0;
   logic [N-1:0]    rd_req = '0;
   logic [N*AW-1:0] rd_addr = '0;
   logic [N*2-1:0]  rd_size = '0;
   logic [N-1:0]    rd_done;
   logic [31:0]     rd_data;
   logic            wr_req = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [1:0]      wr_size = '0;
   logic [31:0]     wr_data = '0;
   logic            wr_done;
   logic            busy;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   logic [39:0] wlog[$];
   int          wcnt0;

   mem_port_arbiter #(.NUM_RD_CH(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_done(rd_done),
      .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
      .wr_data(wr_data), .wr_done(wr_done), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         default: return a[7:0] ^ 8'hA5;
      endcase
   endfunction

   // RAM model: one-cycle read latency; writes are logged as {address, byte}.
   always @(posedge clk) begin
      mem_din <= rom(mem_a);
      if (mem_wr) wlog.push_back({mem_a, mem_dout});
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // From the grant cycle: expect mem_a on the next cycle, then rd_done exactly cyc cycles after grant.
   task automatic rd_wait(input int cyc, input logic [31:0] addr, input logic [N-1:0] done,
                          input logic [31:0] data, input string tag);
      for (int k = 1; k < cyc; k++) begin
         tick(); mid();
         if (k == 1) check({tag, " mem_a"}, mem_a, addr);
         check({tag, " early done"}, rd_done, '0);
      end
      tick(); mid();
      check({tag, " rd_done"}, rd_done, done);
      check({tag, " rd_data"}, rd_data, data);
      check({tag, " busy"}, busy, 1'b0);
   endtask

   initial begin
      logic [N-1:0] first_ch;
      logic [31:0]  first_addr, first_data, second_addr, second_data;
`ifdef MEMARB_RR_EN
      first_ch = 2'b10; first_addr = 32'h101; first_data = 32'h22; second_addr = 32'h100; second_data = 32'h11;
`else
      first_ch = 2'b01; first_addr = 32'h100; first_data = 32'h11; second_addr = 32'h101; second_data = 32'h22;
`endif

      // Reset values
      repeat (2) @(posedge clk);
      mid();
      check("rst mem_a", mem_a, '0);
      check("rst mem_dout", mem_dout, '0);
      check("rst mem_wr", mem_wr, 1'b0);
      check("rst rd_done", rd_done, '0);
      check("rst rd_data", rd_data, '0);
      check("rst wr_done", wr_done, 1'b0);
      check("rst busy", busy, 1'b0);
      tick(); rst = 1'b0;

      // Word read ch0 at 0x100
      tick(); rd_req = 2'b01; rd_addr[31:0] = 32'h100; rd_size[1:0] = 2'd2;
      for (int i = 0; i < 3; i++) begin
         tick(); mid();
         check("word rd mem_a", mem_a, 32'h100 + i);
         if (i == 0) check("word rd busy", busy, 1'b1);
      end
      rd_wait(3, 32'h103, 2'b01, 32'h44332211, "word rd");
      rd_req = '0;

      // Half write 0x1FE / 0xABCD
      tick(); wr_req = 1'b1; wr_addr = 32'h1FE; wr_size = 2'd1; wr_data = 32'h0000ABCD;
      tick(); mid();
      check("half wr b0 mem_wr", mem_wr, 1'b1);
      check("half wr b0 mem_a", mem_a, 32'h1FE);
      check("half wr b0 dout", mem_dout, 8'hCD);
      tick(); mid();
      check("half wr b1 mem_a", mem_a, 32'h1FF);
      check("half wr b1 dout", mem_dout, 8'hAB);
      tick(); mid();
      check("half wr done", wr_done, 1'b1);
      check("half wr idle mem_wr", mem_wr, 1'b0);
      check("half wr busy", busy, 1'b0);
      wr_req = 1'b0;
      check("half wr log b0", wlog[wlog.size()-2], {32'h1FE, 8'hCD});
      check("half wr log b1", wlog[wlog.size()-1], {32'h1FF, 8'hAB});

      // Half write wrapping past the top of the address space
      tick(); wr_req = 1'b1; wr_addr = 32'hFFFF_FFFF; wr_size = 2'd1; wr_data = 32'h0000_1234;
      tick(); mid();
      check("wrap wr mem_a0", mem_a, 32'hFFFF_FFFF);
      check("wrap wr dout0", mem_dout, 8'h34);
      tick(); mid();
      check("wrap wr mem_a1", mem_a, 32'h0);
      check("wrap wr dout1", mem_dout, 8'h12);
      tick(); mid();
      check("wrap wr done", wr_done, 1'b1);
      wr_req = 1'b0;

      // Write vs two reads, then all three again while ch1 is still pending
      tick();
      wr_req = 1'b1; wr_addr = 32'h200; wr_size = 2'd0; wr_data = 32'h5E;
      rd_req = 2'b11; rd_addr = {32'h101, 32'h100}; rd_size = 4'b0000;
      tick(); mid();
      check("arb write first", mem_wr, 1'b1);
      check("arb write addr", mem_a, 32'h200);
      tick(); mid();
      check("arb write done", wr_done, 1'b1);
      wr_req = 1'b0;
      rd_wait(3, 32'h100, 2'b01, 32'h11, "arb rd ch0");
      wr_req = 1'b1; wr_addr = 32'h201; wr_data = 32'h77; rd_req = 2'b11;
      tick(); mid();
      check("arb2 write first", mem_wr, 1'b1);
      check("arb2 write dout", mem_dout, 8'h77);
      tick(); mid();
      check("arb2 write done", wr_done, 1'b1);
      check("arb2 no rd_done", rd_done, '0);
      wr_req = 1'b0;
      rd_wait(3, first_addr, first_ch, first_data, "arb2 rd first");
      rd_req = ~first_ch;
      rd_wait(3, second_addr, ~first_ch, second_data, "arb2 rd second");
      rd_req = '0;

      // IO back-pressure on a byte write to 0x30000
      tick(); wr_req = 1'b1; wr_addr = 32'h30000; wr_size = 2'd0; wr_data = 32'h99; io_buffer_full = 1'b1;
      wcnt0 = wlog.size();
      for (int i = 0; i < 3; i++) begin
         tick(); mid();
         check("io stall mem_wr", mem_wr, 1'b0);
         check("io stall busy", busy, 1'b1);
      end
      tick(); io_buffer_full = 1'b0; mid();
      check("io resume mem_wr", mem_wr, 1'b1);
      check("io resume mem_a", mem_a, 32'h30000);
      check("io resume dout", mem_dout, 8'h99);
      tick(); mid();
      check("io wr_done", wr_done, 1'b1);
      check("io single write", wlog.size() - wcnt0, 1);
      wr_req = 1'b0;

      // Flush of a word read on ch1; pending ch0 granted right after
      tick(); rd_req = 2'b10; rd_addr = {32'h104, 32'h100}; rd_size = {2'd2, 2'd0};
      tick(); rd_req = 2'b11; mid();
      check("flush rd mem_a", mem_a, 32'h104);
      tick(); mid();
      check("flush rd mem_a1", mem_a, 32'h105);
      tick(); flush = 1'b1; mid();
      check("flush cycle done", rd_done, '0);
      tick(); flush = 1'b0; rd_req = 2'b01; mid();
      check("flush busy", busy, 1'b0);
      check("flush no done", rd_done, '0);
      rd_wait(3, 32'h100, 2'b01, 32'h11, "post flush ch0");
      rd_req = '0;

      // rdy low for two cycles during byte 1 of a word read (size 3 means word)
      tick(); rd_req = 2'b01; rd_addr[31:0] = 32'h100; rd_size[1:0] = 2'd3;
      tick(); mid(); check("rdy rd a0", mem_a, 32'h100);
      tick(); mid(); check("rdy rd a1", mem_a, 32'h101);
      tick(); rdy = 1'b0; mid();
      check("rdy low mem_wr", mem_wr, 1'b0);
      check("rdy low done", rd_done, '0);
      tick(); mid();
      check("rdy low rewind", mem_a, 32'h101);
      check("rdy low mem_wr2", mem_wr, 1'b0);
      tick(); rdy = 1'b1; mid();
      check("rdy reissue a1", mem_a, 32'h101);
      tick(); mid(); check("rdy rd a2", mem_a, 32'h102);
      rd_wait(3, 32'h103, 2'b01, 32'h44332211, "rdy rd");
      rd_req = '0;

      // Reset mid-transfer
      tick(); rd_req = 2'b01; rd_size[1:0] = 2'd2;
      tick(); tick(); mid();
      check("midrst busy before", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst busy", busy, 1'b0);
      check("midrst mem_a", mem_a, '0);
      tick(); rst = 1'b0; rd_req = '0;
      for (int i = 0; i < 5; i++) begin
         tick(); mid();
         check("midrst no done", rd_done, '0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
